// File: rtl/cdb_arbiter_buffered.sv
// Common Data Bus arbiter: per-source writeback FIFOs feeding one registered
// CDB slot per cycle, granted by fixed priority or round-robin.
module cdb_arbiter_buffered #(
    parameter int XLEN_P    = 32,
    parameter int PREG_W    = 6,
    parameter int NUM_SRC   = 3,
    parameter int BUF_DEPTH = 2,
    parameter int RR_MODE   = 1,
    localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_SRC-1:0]        wb_valid_i,
    output logic [NUM_SRC-1:0]        wb_ready_o,
    input  logic [NUM_SRC*PREG_W-1:0] wb_tag_i,
    input  logic [NUM_SRC*XLEN_P-1:0] wb_data_i,
    input  logic                      flush_i,
    output logic                      cdb_valid_o,
    output logic [PREG_W-1:0]         cdb_tag_o,
    output logic [XLEN_P-1:0]         cdb_data_o,
    output logic [SRC_W-1:0]          cdb_src_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [PREG_W-1:0] tag_mem  [NUM_SRC][BUF_DEPTH];
    logic [XLEN_P-1:0] data_mem [NUM_SRC][BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr   [NUM_SRC];
    logic [CNT_W-1:0]  count    [NUM_SRC];
    logic [SRC_W-1:0]  rr_ptr;

    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               gnt_valid;
    logic [SRC_W-1:0]   gnt_idx;
    logic [PREG_W-1:0]  gnt_tag;
    logic [XLEN_P-1:0]  gnt_data;

    assign wb_ready_o = ready;

    // Ready looks only at occupancy, so a full buffer refuses input even when it drains this cycle.
    always_comb begin
        ready = '0;
        req   = '0;
        push  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ready[i] = (count[i] != CNT_W'(BUF_DEPTH));
            req[i]   = (count[i] != '0);
            push[i]  = wb_valid_i[i] && ready[i] && !flush_i;
        end
    end

    // Candidate order starts at rr_ptr (round-robin) or at source 0 (fixed).
    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_tag   = '0;
        gnt_data  = '0;
        pop       = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (RR_MODE != 0) begin
                idx = (32'(rr_ptr) + k) % NUM_SRC;
            end else begin
                idx = k;
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (!gnt_valid && (i == idx) && req[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SRC_W'(i);
                    gnt_tag   = tag_mem[i][rd_ptr[i]];
                    gnt_data  = data_mem[i][rd_ptr[i]];
                    pop[i]    = !flush_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= wb_tag_i[i*PREG_W +: PREG_W];
                data_mem[i][wr_ptr[i]] <= wb_data_i[i*XLEN_P +: XLEN_P];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid_o <= 1'b0;
            cdb_tag_o   <= '0;
            cdb_data_o  <= '0;
            cdb_src_o   <= '0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= '0;
            cdb_valid_o <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
            cdb_valid_o <= gnt_valid;
            if (gnt_valid) begin
                cdb_tag_o  <= gnt_tag;
                cdb_data_o <= gnt_data;
                cdb_src_o  <= gnt_idx;
                rr_ptr     <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter_buffered.sv
// Bench for cdb_arbiter_buffered: a fixed-priority and a round-robin instance
// share stimulus and are compared against a queue-based reference model.
module tb_cdb_arbiter_buffered;

    localparam int N  = 3;
    localparam int D  = 2;
    localparam int TW = 6;
    localparam int XW = 32;
    localparam int SW = 2;
    localparam int W  = 1 + TW + XW + SW + N;

    typedef logic [TW+XW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [N-1:0]    wb_valid = '0;
    logic [N*TW-1:0] wb_tag = '0;
    logic [N*XW-1:0] wb_data = '0;

    logic [N-1:0]  rdy_fx, rdy_rr;
    logic          v_fx, v_rr;
    logic [TW-1:0] t_fx, t_rr;
    logic [XW-1:0] d_fx, d_rr;
    logic [SW-1:0] s_fx, s_rr;
    logic [W-1:0]  obs [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = fixed priority, 1 = round-robin
    ent_t          mq [2][N][$];
    int            m_rr    [2];
    logic          m_valid [2];
    logic [TW-1:0] m_tag   [2];
    logic [XW-1:0] m_data  [2];
    logic [SW-1:0] m_src   [2];

    assign obs[0] = {v_fx, t_fx, d_fx, s_fx, rdy_fx};
    assign obs[1] = {v_rr, t_rr, d_rr, s_rr, rdy_rr};

    always #5 clk = ~clk;

    cdb_arbiter_buffered #(.XLEN_P(XW), .PREG_W(TW), .NUM_SRC(N), .BUF_DEPTH(D), .RR_MODE(0)) dut_fx (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid), .wb_ready_o(rdy_fx),
        .wb_tag_i(wb_tag), .wb_data_i(wb_data), .flush_i(flush),
        .cdb_valid_o(v_fx), .cdb_tag_o(t_fx), .cdb_data_o(d_fx), .cdb_src_o(s_fx)
    );

    cdb_arbiter_buffered #(.XLEN_P(XW), .PREG_W(TW), .NUM_SRC(N), .BUF_DEPTH(D), .RR_MODE(1)) dut_rr (
        .clk_i(clk), .rst_i(rst), .wb_valid_i(wb_valid), .wb_ready_o(rdy_rr),
        .wb_tag_i(wb_tag), .wb_data_i(wb_data), .flush_i(flush),
        .cdb_valid_o(v_rr), .cdb_tag_o(t_rr), .cdb_data_o(d_rr), .cdb_src_o(s_rr)
    );

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) mq[m][i].delete();
            m_rr[m] = 0; m_valid[m] = 1'b0; m_tag[m] = '0; m_data[m] = '0; m_src[m] = '0;
        end
    endfunction

    function automatic void model_edge();
        logic [N-1:0] acc;
        int g;
        int s;
        ent_t e;
        if (rst) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) acc[i] = wb_valid[i] && (mq[m][i].size() < D);
            if (flush) begin
                for (int i = 0; i < N; i++) mq[m][i].delete();
                m_rr[m] = 0;
                m_valid[m] = 1'b0;
            end else begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    s = (m == 1) ? (m_rr[m] + k) % N : k;
                    if (g < 0 && mq[m][s].size() > 0) g = s;
                end
                if (g >= 0) begin
                    e = mq[m][g].pop_front();
                    m_valid[m] = 1'b1;
                    m_tag[m]   = e[TW+XW-1:XW];
                    m_data[m]  = e[XW-1:0];
                    m_src[m]   = SW'(g);
                    if (m == 1) m_rr[m] = (g + 1) % N;
                end else begin
                    m_valid[m] = 1'b0;
                end
                for (int i = 0; i < N; i++)
                    if (acc[i]) mq[m][i].push_back({wb_tag[i*TW +: TW], wb_data[i*XW +: XW]});
            end
        end
    endfunction

    function automatic logic [W-1:0] exp_bus(int m);
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) rdy[i] = (mq[m][i].size() != D);
        return {m_valid[m], m_tag[m], m_data[m], m_src[m], rdy};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [TW-1:0] t, input logic [XW-1:0] d);
        wb_valid[i] = v;
        wb_tag[i*TW +: TW] = t;
        wb_data[i*XW +: XW] = d;
    endtask

    task automatic test_reset();
        logic [W-1:0] e0;
        e0 = '0;
        e0[N-1:0] = '1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== e0) begin errors++; $display("FAIL reset_state inst=%0d got=%h exp=%h", m, obs[m], e0); end
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) drive(i, 1'b1, TW'(i + 1), $urandom());
        tick();
        wb_valid = '0;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL reset_preload inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m)); end
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({v_fx, v_rr} !== 2'b00) begin errors++; $display("FAIL reset_async_valid got=%b exp=00", {v_fx, v_rr}); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rdy_fx, rdy_rr} !== 6'b111111) begin errors++; $display("FAIL reset_ready got=%b exp=111111", {rdy_fx, rdy_rr}); end
        repeat (4) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_bus(m) || obs[m][W-1] !== 1'b0) begin
                    errors++; $display("FAIL reset_quiet inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
                end
            end
        end
    endtask

    task automatic test_single();
        drive(1, 1'b1, 6'd5, 32'hDEADBEEF);
        tick();
        wb_valid = '0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL single_accept inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m)); end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m][W-1:N] !== {1'b1, 6'd5, 32'hDEADBEEF, 2'd1} || obs[m] !== exp_bus(m)) begin
                errors++; $display("FAIL single_out inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m][W-1] !== 1'b0 || obs[m] !== exp_bus(m)) begin
                errors++; $display("FAIL single_once inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
            end
        end
    endtask

    task automatic drain(input string name);
        wb_valid = '0;
        repeat (8) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL %s_drain inst=%0d got=%h exp=%h", name, m, obs[m], exp_bus(m)); end
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [TW-1:0] tag0, tag2;
        logic [SW-1:0] prev;
        logic have_prev;
        int n0, n2;
        tag0 = 6'd0; tag2 = 6'd32; have_prev = 1'b0; n0 = 0; n2 = 0; prev = '0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int c = 0; c < 24; c++) begin
            drive(0, 1'b1, tag0, $urandom());
            drive(2, 1'b1, tag2, $urandom());
            tag0++; tag2++;
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL rr_bus inst=%0d cyc=%0d got=%h exp=%h", m, c, obs[m], exp_bus(m)); end
            end
            if (v_rr) begin
                if (have_prev) begin
                    checks++;
                    if (s_rr === prev) begin errors++; $display("FAIL rr_alternate cyc=%0d got=%0d prev=%0d", c, s_rr, prev); end
                end
                prev = s_rr; have_prev = 1'b1;
                if (s_rr == 2'd0) n0++;
                if (s_rr == 2'd2) n2++;
            end
        end
        checks++;
        if (n0 < 10 || n2 < 10) begin errors++; $display("FAIL rr_starve got n0=%0d n2=%0d exp >=10 each", n0, n2); end
        drain("rr");
    endtask

    task automatic test_fixed_priority();
        int early;
        int got_n;
        logic [TW-1:0] got_t [2];
        int got_c [2];
        early = 0; got_n = 0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(0, 1'b1, TW'(40 + c), $urandom());
            drive(1, c < 2, (c == 0) ? 6'd7 : 6'd8, $urandom());
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL fixed_bus inst=%0d cyc=%0d got=%h exp=%h", m, c, obs[m], exp_bus(m)); end
            end
            if (v_fx && s_fx === 2'd1) early++;
        end
        checks++;
        if (rdy_fx[1] !== 1'b0 || early != 0) begin
            errors++; $display("FAIL fixed_block got ready1=%b grants1=%0d exp ready1=0 grants1=0", rdy_fx[1], early);
        end
        wb_valid = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL fixed_release inst=%0d cyc=%0d got=%h exp=%h", m, c, obs[m], exp_bus(m)); end
            end
            if (v_fx && s_fx === 2'd1) begin
                if (got_n < 2) begin got_t[got_n] = t_fx; got_c[got_n] = c; end
                got_n++;
            end
        end
        checks++;
        if (got_n != 2 || got_t[0] !== 6'd7 || got_t[1] !== 6'd8 || got_c[1] != got_c[0] + 1) begin
            errors++; $display("FAIL fixed_order got n=%0d tags=%0d,%0d exp n=2 tags=7,8 consecutive", got_n, got_t[0], got_t[1]);
        end
    endtask

    task automatic test_buffer_full();
        logic [N-1:0] seen;
        int nv;
        seen = '0; nv = 0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < N; i++) drive(i, 1'b1, TW'($urandom_range(0, 63)), $urandom());
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_bus(m)) begin errors++; $display("FAIL full_bus inst=%0d cyc=%0d got=%h exp=%h", m, c, obs[m], exp_bus(m)); end
            end
            seen |= ~rdy_rr;
            if (c >= 1 && v_rr) nv++;
        end
        checks++;
        if (seen !== 3'b111) begin errors++; $display("FAIL full_ready got seen_full=%b exp=111", seen); end
        checks++;
        if (nv != 39) begin errors++; $display("FAIL full_throughput got=%0d exp=39", nv); end
        drain("full");
    endtask

    task automatic test_flush();
        flush = 1'b1; tick(); flush = 1'b0;
        drive(1, 1'b1, 6'd11, $urandom());
        drive(2, 1'b1, 6'd12, $urandom());
        tick();
        drive(0, 1'b1, 6'd13, $urandom());
        drive(1, 1'b1, 6'd14, $urandom());
        drive(2, 1'b1, 6'd15, $urandom());
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m][W-1] !== 1'b1 || obs[m][W-2 -: TW] !== 6'd11 || obs[m] !== exp_bus(m)) begin
                errors++; $display("FAIL flush_pre inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
            end
        end
        wb_valid = '0;
        drive(0, 1'b1, 6'd16, $urandom());
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wb_valid = '0;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m][W-1] !== 1'b0 || obs[m] !== exp_bus(m)) begin
                errors++; $display("FAIL flush_valid inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
            end
        end
        repeat (5) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ((obs[m][W-1] === 1'b1 && obs[m][W-2 -: TW] >= 6'd12 && obs[m][W-2 -: TW] <= 6'd16) || obs[m] !== exp_bus(m)) begin
                    errors++; $display("FAIL flush_leak inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
                end
            end
        end
        drive(1, 1'b1, 6'd21, $urandom());
        drive(2, 1'b1, 6'd20, $urandom());
        tick();
        wb_valid = '0;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({obs[m][W-1], obs[m][W-2 -: TW], obs[m][N +: SW]} !== {1'b1, 6'd21, 2'd1} || obs[m] !== exp_bus(m)) begin
                errors++; $display("FAIL flush_fresh1 inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({obs[m][W-1], obs[m][W-2 -: TW], obs[m][N +: SW]} !== {1'b1, 6'd20, 2'd2} || obs[m] !== exp_bus(m)) begin
                errors++; $display("FAIL flush_fresh2 inst=%0d got=%h exp=%h", m, obs[m], exp_bus(m));
            end
        end
        drain("flush");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed_priority();
        test_buffer_full();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
